// File: rtl/load_status_aggregator.sv
// ---------------------------------------------------------------------------
// load_status_aggregator
//
// Purpose:
//   Combines the done/error status of NUM_CH loader channels (FRAM, flash,
//   and future sources) into one load-session result. A session is opened
//   by a start pulse. The set of channels taking part is captured from
//   ch_enable at that moment. Each channel's done flag is sticky. The
//   session ends in DONE when every enabled channel has reported done. It
//   ends in FAIL when an enabled channel reports an error, or when the
//   watchdog expires. The result is held until ack returns the block to
//   IDLE.
//
// Parameters:
//   NUM_CH       number of loader channels (1..16)
//   TIMEOUT_W    width of the watchdog counter
//   TIMEOUT_CYC  session timeout in sys_clk cycles; 0 disables the watchdog
//   CH_W         width of the channel index, max(1, clog2(NUM_CH))
//
// Ports:
//   sys_clk         in   system clock, rising edge
//   glbl_rst_n      in   asynchronous active-low reset
//   start           in   1-cycle pulse, opens a session from IDLE
//   ch_enable       in   channels taking part, sampled on an accepted start
//   ch_done         in   per-channel done pulses or levels
//   ch_error        in   per-channel error pulses or levels
//   ack             in   clears a held DONE/FAIL result, back to IDLE
//   load_busy       out  high while the session runs
//   load_ram_done   out  session completed OK, held until ack
//   load_ram_error  out  session failed, held until ack
//   load_evt        out  1-cycle pulse on entry to DONE or FAIL
//   err_ch_id       out  channel blamed for a failure
//   err_code        out  00 none, 01 channel error, 10 timeout
//   done_mask       out  sticky per-channel done flags
// ---------------------------------------------------------------------------
module load_status_aggregator #(
  parameter int                   NUM_CH      = 2,
  parameter int                   TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 24'd10_000_000,
  localparam int                  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              glbl_rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_error,
  input  logic              ack,
  output logic              load_busy,
  output logic              load_ram_done,
  output logic              load_ram_error,
  output logic              load_evt,
  output logic [CH_W-1:0]   err_ch_id,
  output logic [1:0]        err_code,
  output logic [NUM_CH-1:0] done_mask
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_CHERR   = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  localparam bit                   TO_EN   = (TIMEOUT_CYC != '0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1'b1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [NUM_CH-1:0]    en_q, en_d;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 ok_q, ok_d;
  logic                 fail_q, fail_d;
  logic                 evt_q, evt_d;
  logic [CH_W-1:0]      id_q, id_d;
  logic [1:0]           code_q, code_d;

  logic [NUM_CH-1:0]    done_now;
  logic [NUM_CH-1:0]    err_now;
  logic [NUM_CH-1:0]    done_all;

  // Lowest set bit of a channel vector. When several channels misbehave
  // in the same cycle, the lowest index gets the blame.
  function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CH_W'(i);
    end
  endfunction

  // Done and error are only counted for channels that take part in the
  // session. done_all includes a done arriving in the current cycle, so
  // the last done completes the session in the same cycle it arrives.
  assign done_now = ch_done & en_q;
  assign err_now  = ch_error & en_q;
  assign done_all = mask_q | done_now;

  // Next-state logic. The status flags are derived from the next state so
  // that every output comes straight from a register.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    code_d  = code_q;
    evt_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d   = ch_enable;
          mask_d = '0;
          cnt_d  = '0;
          id_d   = '0;
          code_d = CODE_NONE;
          // A session with no channels has nothing to wait for.
          if (ch_enable == '0) begin
            state_d = S_DONE;
            evt_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        mask_d = done_all;
        // Priority: error > completion > timeout.
        if (err_now != '0) begin
          state_d = S_FAIL;
          evt_d   = 1'b1;
          code_d  = CODE_CHERR;
          id_d    = lowest_idx(err_now);
        end else if ((done_all & en_q) == en_q) begin
          state_d = S_DONE;
          evt_d   = 1'b1;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_FAIL;
          evt_d   = 1'b1;
          code_d  = CODE_TIMEOUT;
          id_d    = lowest_idx(en_q & ~done_all);
        end else if (cnt_q != CNT_MAX) begin
          // The counter saturates so that, with the watchdog disabled, it
          // can never wrap around.
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE, S_FAIL: begin
        // The result is held until ack. If start arrives together with
        // ack, start is dropped because this branch never looks at it.
        if (ack) begin
          state_d = S_IDLE;
          mask_d  = '0;
          id_d    = '0;
          code_d  = CODE_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
        id_d    = '0;
        code_d  = CODE_NONE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    ok_d   = (state_d == S_DONE);
    fail_d = (state_d == S_FAIL);
  end

  // State and output registers. Reset aborts any session at once and
  // clears every output, so no load_evt is produced for an aborted run.
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      evt_q   <= 1'b0;
      id_q    <= '0;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
      evt_q   <= evt_d;
      id_q    <= id_d;
      code_q  <= code_d;
    end
  end

  assign load_busy      = busy_q;
  assign load_ram_done  = ok_q;
  assign load_ram_error = fail_q;
  assign load_evt       = evt_q;
  assign err_ch_id      = id_q;
  assign err_code       = code_q;
  assign done_mask      = mask_q;

endmodule
